// File: rtl/krz_sysbus_arb.sv
// -----------------------------------------------------------------------------
// krz_sysbus_arb
// Round-robin arbiter sharing the single Wishbone slave port of the KRZ system
// peripheral bus between M masters. One transaction is in flight at a time,
// request and response paths are registered, and a per-transaction watchdog
// terminates accesses that a peripheral never acknowledges.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among pending strobes
// BUSY  | access presented on s_*; wait for s_ack_i or watchdog expiry
// RESP  | one-cycle ack/err/timeout pulse to the owner; no arbitration
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   m_adr_i/m_dat_i/m_we_i/m_stb_i   per-master request
//   m_dat_o         shared read data, valid with m_ack_o
//   m_ack_o/m_err_o per-master one-cycle ack / error (timeout)
//   s_adr_o/s_dat_o/s_we_o/s_stb_o   to krz_sysbus
//   s_dat_i/s_ack_i from krz_sysbus
//   grant_o         one-hot current owner, zero in IDLE
//   timeout_o       one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module krz_sysbus_arb #(
    parameter int          M        = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M-1:0][23:0]   m_adr_i,
    input  logic [M-1:0][31:0]   m_dat_i,
    input  logic [M-1:0]         m_we_i,
    input  logic [M-1:0]         m_stb_i,
    output logic [31:0]          m_dat_o,
    output logic [M-1:0]         m_ack_o,
    output logic [M-1:0]         m_err_o,
    output logic [23:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic                 s_we_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    output logic [M-1:0]         grant_o,
    output logic                 timeout_o
);

    localparam int              IW       = (M > 1) ? $clog2(M) : 1;
    localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [M-1:0]    ONE      = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [31:0]     m_dat_d;
    logic [M-1:0]    m_ack_d, m_err_d, grant_d;
    logic [23:0]     s_adr_d;
    logic [31:0]     s_dat_d;
    logic            s_we_d, s_stb_d, timeout_d;

    logic [IW-1:0]   winner;
    logic            found;
    logic            timed_out;

    // Search starts one past the last owner and wraps, so the last owner
    // has the lowest priority in the next arbitration.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        for (int i = 1; i <= M; i++) begin
            if (!found && m_stb_i[(int'(last_q) + i) % M]) begin
                winner = IW'((int'(last_q) + i) % M);
                found  = 1'b1;
            end
        end
    end

    // Counter holds the number of completed BUSY cycles minus one, so reaching
    // TIMEOUT-1 on a sampling edge means TIMEOUT full cycles have elapsed.
    assign timed_out = (TIMEOUT != 0) && !s_ack_i && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_dat_d   = m_dat_o;
        m_ack_d   = '0;
        m_err_d   = '0;
        timeout_d = 1'b0;
        grant_d   = grant_o;
        s_adr_d   = s_adr_o;
        s_dat_d   = s_dat_o;
        s_we_d    = s_we_o;
        s_stb_d   = s_stb_o;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                s_stb_d = 1'b0;
                if (found) begin
                    owner_d = winner;
                    s_adr_d = m_adr_i[winner];
                    s_dat_d = m_dat_i[winner];
                    s_we_d  = m_we_i[winner];
                    s_stb_d = 1'b1;
                    grant_d = ONE << winner;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Ack takes precedence over a watchdog expiry in the same cycle.
                if (s_ack_i) begin
                    s_stb_d = 1'b0;
                    m_ack_d = grant_o;
                    m_dat_d = s_dat_i;
                    last_d  = owner_q;
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    s_stb_d   = 1'b0;
                    m_ack_d   = grant_o;
                    m_err_d   = grant_o;
                    m_dat_d   = ERR_DATA;
                    timeout_d = 1'b1;
                    last_d    = owner_q;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                s_stb_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            last_q    <= IW'(M - 1);
            cnt_q     <= '0;
            m_dat_o   <= '0;
            m_ack_o   <= '0;
            m_err_o   <= '0;
            timeout_o <= 1'b0;
            grant_o   <= '0;
            s_adr_o   <= '0;
            s_dat_o   <= '0;
            s_we_o    <= 1'b0;
            s_stb_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_dat_o   <= m_dat_d;
            m_ack_o   <= m_ack_d;
            m_err_o   <= m_err_d;
            timeout_o <= timeout_d;
            grant_o   <= grant_d;
            s_adr_o   <= s_adr_d;
            s_dat_o   <= s_dat_d;
            s_we_o    <= s_we_d;
            s_stb_o   <= s_stb_d;
        end
    end

endmodule
